// File: rtl/lycalo_pkg.sv
// lycalo_pkg: shared defaults and slot-extraction widths for the lycalo charge-sum block
package lycalo_pkg;
  localparam int NSLOT_DEF  = 16;
  localparam int SLOT_W_DEF = 64;
  localparam int Q_W_DEF    = 25;
  localparam int SUM_W_DEF  = 29;
  localparam int DATA_W     = 1024;
  localparam int MASK_W     = 256;
  localparam int THR_W      = 32;
endpackage

// File: rtl/lycalo_slot_pack.sv
// lycalo_slot_pack: packs NSLOT signed charges into DATA slots, sign-extended to the slot pitch
module lycalo_slot_pack
  import lycalo_pkg::*;
#(
  parameter int NSLOT  = NSLOT_DEF,
  parameter int SLOT_W = SLOT_W_DEF,
  parameter int Q_W    = Q_W_DEF
) (
  input  logic [NSLOT*Q_W-1:0] q,
  output logic [DATA_W-1:0]    data
);
  always_comb begin
    data = '0;
    for (int i = 0; i < NSLOT; i++) data[SLOT_W*i +: SLOT_W] = SLOT_W'($signed(q[Q_W*i +: Q_W]));
  end
endmodule

// File: rtl/lycalo_block.sv
// lycalo_block: two-stage masked slot-charge sum with sum-threshold and per-slot OR triggers
module lycalo_block
  import lycalo_pkg::*;
#(
  parameter int NSLOT  = NSLOT_DEF,
  parameter int SLOT_W = SLOT_W_DEF,
  parameter int Q_W    = Q_W_DEF,
  parameter int SUM_W  = SUM_W_DEF
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic [DATA_W-1:0] DATA,
  input  logic [THR_W-1:0]  LYCALOTHR,
  input  logic [MASK_W-1:0] LYCALOMASK,
  output logic              LYCALOTRG,
  output logic              LYCALOORTRG,
  output logic [SUM_W-1:0]  LYCALOQSUM
);
  logic signed [Q_W-1:0]   charge_d [NSLOT];
  logic signed [Q_W-1:0]   charge_q [NSLOT];
  logic signed [THR_W-1:0] thr_d, thr_q;
  logic [NSLOT-1:0]        flag_d, flag_q;
  logic signed [SUM_W-1:0] sum_d, sum_q;
  logic                    trg_d, trg_q, ortrg_d, ortrg_q;
  logic                    unused_bits;
  // upper slot bits and reserved mask bits are intentionally ignored
  assign unused_bits = ^{DATA, LYCALOMASK};
  always_comb begin
    thr_d = LYCALOTHR;
    sum_d = '0;
    for (int i = 0; i < NSLOT; i++) begin
      charge_d[i] = LYCALOMASK[i] ? DATA[SLOT_W*i +: Q_W] : '0;
      flag_d[i]   = LYCALOMASK[i] && (THR_W'(charge_d[i]) > thr_d);
      sum_d       = sum_d + SUM_W'(charge_q[i]);
    end
    trg_d   = THR_W'(sum_d) > thr_q;
    ortrg_d = |flag_q;
  end
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      charge_q <= '{default: '0};
      thr_q    <= '0;
      flag_q   <= '0;
      sum_q    <= '0;
      trg_q    <= 1'b0;
      ortrg_q  <= 1'b0;
    end else begin
      charge_q <= charge_d;
      thr_q    <= thr_d;
      flag_q   <= flag_d;
      sum_q    <= sum_d;
      trg_q    <= trg_d;
      ortrg_q  <= ortrg_d;
    end
  end
  assign LYCALOQSUM  = sum_q;
  assign LYCALOTRG   = trg_q;
  assign LYCALOORTRG = ortrg_q;
endmodule

// File: tb/tb_lycalo_block.sv
// tb_lycalo_block: table-driven pipelined check of lycalo_block plus reset corner sequences
module tb_lycalo_block;
  logic          CLK = 1'b0;
  logic          RSTN = 1'b0;
  logic [1023:0] DATA = '0;
  logic [31:0]   LYCALOTHR = '0;
  logic [255:0]  LYCALOMASK = '0;
  logic          LYCALOTRG, LYCALOORTRG;
  logic [28:0]   LYCALOQSUM;
  logic signed [28:0] qsum;
  int n_vec = 0;
  int n_bad = 0;

  assign qsum = LYCALOQSUM;

  lycalo_block dut (
    .CLK(CLK), .RSTN(RSTN), .DATA(DATA), .LYCALOTHR(LYCALOTHR), .LYCALOMASK(LYCALOMASK),
    .LYCALOTRG(LYCALOTRG), .LYCALOORTRG(LYCALOORTRG), .LYCALOQSUM(LYCALOQSUM)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1023:0] data;
    logic [31:0]   thr;
    logic [255:0]  mask;
    int            sum;
    bit            trg;
    bit            ortrg;
  } vec_t;

  localparam int NV = 15;
  vec_t tv [NV];

  function automatic logic [1023:0] slots(input int a0, a1, a2, a3, a4, rest, input logic [38:0] junk);
    logic [1023:0] d;
    int a [5];
    int v;
    a = '{a0, a1, a2, a3, a4};
    d = '0;
    for (int i = 0; i < 16; i++) begin
      v = (i < 5) ? a[i] : rest;
      d[64*i +: 64] = {junk, 25'(v)};
    end
    return d;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int sum, input bit trg, input bit ortrg);
    chk({tag, " qsum"}, int'(qsum), sum);
    chk({tag, " trg"}, int'(LYCALOTRG), int'(trg));
    chk({tag, " ortrg"}, int'(LYCALOORTRG), int'(ortrg));
  endtask

  task automatic setv(input int k, input logic [1023:0] d, input logic [31:0] t, input logic [255:0] m,
                      input int s, input bit g, input bit o);
    tv[k] = '{data: d, thr: t, mask: m, sum: s, trg: g, ortrg: o};
  endtask

  initial begin
    logic [1023:0] d_a, d_b, d_c, d_lo, d_hi, d_lo_j, d_hi_j;
    logic [255:0]  m_all, m_one, m_res;
    d_a    = slots(10, 20, 30, 40, 0, 0, '0);
    d_b    = slots(10, 20, 30, 40, -10, 0, '0);
    d_c    = slots(-100, 0, 0, 0, 0, 0, '0);
    d_lo   = slots(-16777216, -16777216, -16777216, -16777216, -16777216, -16777216, '0);
    d_hi   = slots(16777215, 16777215, 16777215, 16777215, 16777215, 16777215, '0);
    d_lo_j = slots(-16777216, -16777216, -16777216, -16777216, -16777216, -16777216, 39'h5A_5A5A_5A5A);
    d_hi_j = slots(16777215, 16777215, 16777215, 16777215, 16777215, 16777215, '1);
    m_all  = 256'hFFFF;
    m_one  = 256'h0001;
    m_res  = {{240{1'b1}}, 16'h0001};
    setv(0,  d_a,    32'd0,          m_all, 100,        1, 1);
    setv(1,  d_b,    32'd90,         m_all, 90,         0, 0);
    setv(2,  d_b,    32'd89,         m_all, 90,         1, 0);
    setv(3,  d_c,    -32'sd101,      m_all, -100,       1, 1);
    setv(4,  d_c,    -32'sd100,      m_all, -100,       0, 1);
    setv(5,  d_a,    32'd10,         m_one, 10,         0, 0);
    setv(6,  d_a,    32'd9,          m_one, 10,         1, 1);
    setv(7,  d_lo,   32'd0,          m_all, -268435456, 0, 0);
    setv(8,  d_hi,   32'd0,          m_all, 268435440,  1, 1);
    setv(9,  d_lo_j, 32'd0,          m_all, -268435456, 0, 0);
    setv(10, d_hi_j, 32'd0,          m_all, 268435440,  1, 1);
    setv(11, d_hi,   32'd0,          '0,    0,          0, 0);
    setv(12, d_lo,   32'h8000_0000,  m_all, -268435456, 1, 1);
    setv(13, d_hi,   32'h7FFF_FFFF,  m_all, 268435440,  0, 0);
    setv(14, d_a,    32'd10,         m_res, 10,         0, 0);

    repeat (2) @(negedge CLK);
    chk_out("reset", 0, 0, 0);
    RSTN = 1'b1;

    // back-to-back stream: vector k appears at the outputs two edges after it is driven
    for (int i = 0; i < NV + 2; i++) begin
      @(negedge CLK);
      if (i >= 2) chk_out($sformatf("vec%0d", i - 2), tv[i-2].sum, tv[i-2].trg, tv[i-2].ortrg);
      if (i < NV) begin
        DATA = tv[i].data;
        LYCALOTHR = tv[i].thr;
        LYCALOMASK = tv[i].mask;
      end
    end

    // one-cycle reset in the middle of a steady stream
    DATA = d_a;
    LYCALOTHR = '0;
    LYCALOMASK = m_all;
    repeat (3) @(negedge CLK);
    chk_out("pre_rst", 100, 1, 1);
    RSTN = 1'b0;
    @(negedge CLK);
    chk_out("in_rst", 0, 0, 0);
    RSTN = 1'b1;
    @(negedge CLK);
    chk_out("post_rst1", 0, 0, 0);
    @(negedge CLK);
    chk_out("post_rst2", 100, 1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
